// File: rtl/pipe_merge_arbiter.sv
// Merges two pipeline result streams through per-source skid FIFOs onto one sink.
// Round-robin arbitration with grant lock while the sink stalls; optional GLOBAL_STALL_EN ties both stalls together.
module pipe_merge_arbiter #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int SKID       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p1_valid,
  input  logic [DATA_W-1:0] p1_data,
  input  logic              p2_valid,
  input  logic [DATA_W-1:0] p2_data,
  input  logic              flush_1,
  input  logic              flush_2,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              stall_1,
  output logic              stall_2,
  output logic [1:0]        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    ARB_OPEN = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  logic [DATA_W-1:0] r_mem [2][FIFO_DEPTH];
  logic [AW-1:0]     r_wp  [2];
  logic [AW-1:0]     r_rp  [2];
  logic [CW-1:0]     r_cnt [2];
  logic [1:0]        r_ovf;
  logic              r_stall_1;
  logic              r_stall_2;
  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_lock_src;
  logic              r_last_grant;

  logic [1:0]        w_push;
  logic [1:0]        w_flush;
  logic [DATA_W-1:0] w_in_data [2];
  logic [1:0]        w_ne;
  logic [1:0]        w_full;
  logic [1:0]        w_pop;
  logic [1:0]        w_push_ok;
  logic [CW-1:0]     w_cnt_nxt [2];
  logic [1:0]        w_stall_lane;
  logic              w_grant;
  logic              w_valid;
  logic              w_xfer;

  assign w_push       = {p2_valid, p1_valid};
  assign w_flush      = {flush_2, flush_1};
  assign w_in_data[0] = p1_data;
  assign w_in_data[1] = p2_data;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_ne[i]   = (r_cnt[i] != '0);
      w_full[i] = (r_cnt[i] == CW'(FIFO_DEPTH));
    end
  end

  // Grant: held source while locked, otherwise alternate when both have data.
  always_comb begin
    w_grant = 1'b0;
    if (r_state == ARB_HOLD) begin
      w_grant = r_lock_src;
    end else if (w_ne[0] && w_ne[1]) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = w_ne[1] & ~w_ne[0];
    end
  end

  assign w_valid = w_ne[0] | w_ne[1];
  assign w_xfer  = w_valid & out_ready;

  always_comb begin
    w_pop[0] = w_xfer & (w_grant == 1'b0);
    w_pop[1] = w_xfer & (w_grant == 1'b1);
  end

  // A flush of the offered lane is the only event allowed to break the lock.
  always_comb begin
    w_state_nxt = ARB_OPEN;
    if (w_valid && !out_ready && !w_flush[w_grant]) begin
      w_state_nxt = ARB_HOLD;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_push_ok[i] = w_push[i] & ~w_flush[i] & (~w_full[i] | w_pop[i]);
      if (w_flush[i]) begin
        w_cnt_nxt[i] = '0;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CW'(w_push_ok[i]) - CW'(w_pop[i]);
      end
      w_stall_lane[i] = ((CW'(FIFO_DEPTH) - w_cnt_nxt[i]) <= CW'(SKID));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push_ok[i]) begin
        r_mem[i][r_wp[i]] <= w_in_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_cnt[i] <= '0;
      end
      r_ovf <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_flush[i]) begin
          r_wp[i] <= '0;
          r_rp[i] <= '0;
        end else begin
          if (w_push_ok[i]) r_wp[i] <= r_wp[i] + 1'b1;
          if (w_pop[i])     r_rp[i] <= r_rp[i] + 1'b1;
        end
        r_cnt[i] <= w_cnt_nxt[i];
        if (w_push[i] && !w_flush[i] && w_full[i] && !w_pop[i]) begin
          r_ovf[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ARB_OPEN;
      r_lock_src   <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == ARB_HOLD) r_lock_src   <= w_grant;
      if (w_xfer)                  r_last_grant <= w_grant;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_1 <= 1'b0;
      r_stall_2 <= 1'b0;
    end else begin
`ifdef GLOBAL_STALL_EN
      r_stall_1 <= w_stall_lane[0] | w_stall_lane[1];
      r_stall_2 <= w_stall_lane[0] | w_stall_lane[1];
`else
      r_stall_1 <= w_stall_lane[0];
      r_stall_2 <= w_stall_lane[1];
`endif
    end
  end

  assign out_valid = w_valid;
  assign out_src   = w_grant;
  assign out_data  = w_valid ? r_mem[w_grant][r_rp[w_grant]] : '0;
  assign stall_1   = r_stall_1;
  assign stall_2   = r_stall_2;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_pipe_merge_arbiter.sv
// Bench for pipe_merge_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_merge_arbiter;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int SK = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         p1_valid = 1'b0, p2_valid = 1'b0;
  logic [W-1:0] p1_data = '0, p2_data = '0;
  logic         flush_1 = 1'b0, flush_2 = 1'b0, out_ready = 1'b0;
  logic         out_valid, out_src, stall_1, stall_2;
  logic [W-1:0] out_data;
  logic [1:0]   overflow;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  pipe_merge_arbiter #(.DATA_W(W), .FIFO_DEPTH(D), .SKID(SK)) dut (
    .clk(clk), .reset(reset),
    .p1_valid(p1_valid), .p1_data(p1_data),
    .p2_valid(p2_valid), .p2_data(p2_data),
    .flush_1(flush_1), .flush_2(flush_2),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .stall_1(stall_1), .stall_2(stall_2), .overflow(overflow)
  );

  // Reference model: FIFO contents as queues plus the arbitration memory.
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];
  logic         m_last, m_lock, m_lock_src, m_s1, m_s2;
  logic [1:0]   m_ovf;
  logic [W:0]   got_q[$];

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_valid();
    return (exp_q1.size() > 0) || (exp_q2.size() > 0);
  endfunction

  function automatic logic m_grant();
    if (m_lock) return m_lock_src;
    if (exp_q1.size() > 0 && exp_q2.size() > 0) return ~m_last;
    return (exp_q1.size() == 0) && (exp_q2.size() > 0);
  endfunction

  always @(posedge clk or negedge reset) begin : model
    logic g, v, fl_g;
    if (!reset) begin
      exp_q1.delete(); exp_q2.delete();
      m_last = 1'b1; m_lock = 1'b0; m_lock_src = 1'b0;
      m_s1 = 1'b0; m_s2 = 1'b0; m_ovf = 2'b00;
    end else begin
      v = m_valid();
      g = m_grant();
      fl_g = g ? flush_2 : flush_1;
      if (v && out_ready) begin
        if (g) void'(exp_q2.pop_front());
        else   void'(exp_q1.pop_front());
        m_last = g;
        m_lock = 1'b0;
      end else begin
        m_lock = v && !fl_g;
        if (m_lock) m_lock_src = g;
      end
      if (flush_1) exp_q1.delete();
      else if (p1_valid) begin
        if (exp_q1.size() < D) exp_q1.push_back(p1_data);
        else m_ovf[0] = 1'b1;
      end
      if (flush_2) exp_q2.delete();
      else if (p2_valid) begin
        if (exp_q2.size() < D) exp_q2.push_back(p2_data);
        else m_ovf[1] = 1'b1;
      end
      m_s1 = (D - exp_q1.size()) <= SK;
      m_s2 = (D - exp_q2.size()) <= SK;
`ifdef GLOBAL_STALL_EN
      m_s1 = m_s1 | ((D - exp_q2.size()) <= SK);
      m_s2 = m_s1;
`endif
    end
  end

  // Compare process: mid-cycle, inputs already set for the coming edge.
  always @(negedge clk) begin : compare
    logic v, g;
    logic [W-1:0] d;
    v = m_valid();
    g = m_grant();
    d = '0;
    if (v) d = g ? exp_q2[0] : exp_q1[0];
    chk("out_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, v});
    if (v && out_valid) begin
      chk("out_src", {{W{1'b0}}, out_src}, {{W{1'b0}}, g});
      chk("out_data", {1'b0, out_data}, {1'b0, d});
    end
    chk("stall_1", {{W{1'b0}}, stall_1}, {{W{1'b0}}, m_s1});
    chk("stall_2", {{W{1'b0}}, stall_2}, {{W{1'b0}}, m_s2});
    chk("overflow", {{(W-1){1'b0}}, overflow}, {{(W-1){1'b0}}, m_ovf});
    if (out_valid && out_ready) got_q.push_back({out_src, out_data});
  end

  // Apply inputs (called just after a rising edge), then let one edge consume them.
  task automatic cyc(input logic v1, input logic [W-1:0] d1, input logic v2,
                     input logic [W-1:0] d2, input logic rdy,
                     input logic f1, input logic f2);
    p1_valid = v1; p1_data = d1; p2_valid = v2; p2_data = d2;
    out_ready = rdy; flush_1 = f1; flush_2 = f2;
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, rdy, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(1'b0, 2);
    reset = 1'b1;
    got_q.delete();
  endtask

  task automatic chk_log(input int idx, input logic src, input logic [W-1:0] data);
    logic [W:0] got;
    got = (idx < got_q.size()) ? got_q[idx] : {1'b1, {W{1'b1}}} ^ {src, data} ^ {1'b1, {W{1'b1}}} ^ 1;
    chk($sformatf("sink_word%0d", idx), got, {src, data});
  endtask

  initial begin
    @(posedge clk); #1;
    // Reset state and interleaved two-lane ordering
    do_reset();
    chk("rst_out_valid", {{W{1'b0}}, out_valid}, '0);
    chk("rst_out_data", {1'b0, out_data}, '0);
    chk("rst_overflow", {{(W-1){1'b0}}, overflow}, '0);
    cyc(1'b1, 32'hA, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 4);
    chk("order_count", W'(got_q.size()), W'(4));
    chk_log(0, 1'b0, 32'hA);
    chk_log(1, 1'b1, 32'h1);
    chk_log(2, 1'b0, 32'hB);
    chk_log(3, 1'b1, 32'h2);

    // Lane 1 fills with sink stalled, then overflows
    do_reset();
    cyc(1'b1, 32'h100, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("stall1_cnt1", {{W{1'b0}}, stall_1}, '0);
    cyc(1'b1, 32'h101, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("stall1_cnt2", {{W{1'b0}}, stall_1}, 1);
`ifdef GLOBAL_STALL_EN
    chk("stall2_cnt2", {{W{1'b0}}, stall_2}, 1);
`else
    chk("stall2_cnt2", {{W{1'b0}}, stall_2}, 0);
`endif
    cyc(1'b1, 32'h102, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h103, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("held_head", {1'b0, out_data}, {1'b0, 32'h100});
    cyc(1'b1, 32'h104, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", {{(W-1){1'b0}}, overflow}, 2'b01);
    idle(1'b1, 6);
    chk("ovf_sticky", {{(W-1){1'b0}}, overflow}, 2'b01);
    chk("drained", {{W{1'b0}}, out_valid}, '0);
    chk("drop_count", W'(got_q.size()), W'(4));
    chk_log(3, 1'b0, 32'h103);

    // Flush a locked lane
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, W'(32'h200 + i), 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_stall", {{W{1'b0}}, stall_1}, 1);
    cyc(1'b1, 32'h2FF, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", {{W{1'b0}}, out_valid}, '0);
    chk("flush_stall", {{W{1'b0}}, stall_1}, '0);
    chk("flush_ovf", {{(W-1){1'b0}}, overflow}, '0);

    // Full lane 2 with push and pop in the same cycle
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, W'(32'h300 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 32'h304, 1'b1, 1'b0, 1'b0);
    chk("pp_ovf", {{(W-1){1'b0}}, overflow}, '0);
    chk("pp_stall2", {{W{1'b0}}, stall_2}, 1);
    chk("pp_head", {1'b0, out_data}, {1'b0, 32'h301});
    idle(1'b1, 6);
    chk("pp_count", W'(got_q.size()), W'(5));
    for (int i = 0; i < 5; i++) chk_log(i, 1'b1, W'(32'h300 + i));

    // Asynchronous reset in the middle of a burst
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, W'(32'h400 + i), 1'b1, W'(32'h410 + i), 1'b0, 1'b0, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk("arst_valid", {{W{1'b0}}, out_valid}, '0);
    chk("arst_data", {1'b0, out_data}, '0);
    chk("arst_src", {{W{1'b0}}, out_src}, '0);
    chk("arst_stall", {{(W-1){1'b0}}, stall_2, stall_1}, '0);
    @(posedge clk); #1;
    idle(1'b0, 1);
    reset = 1'b1;
    cyc(1'b1, 32'h501, 1'b1, 32'h502, 1'b0, 1'b0, 1'b0);
    chk("first_grant_src", {{W{1'b0}}, out_src}, '0);
    chk("first_grant_data", {1'b0, out_data}, {1'b0, 32'h501});

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      cyc(1'($urandom_range(0, 2) != 0), $urandom,
          1'($urandom_range(0, 2) != 0), $urandom,
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 40) == 0));
    end
    idle(1'b1, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
